// File: rtl/collision_scanner_pkg.sv
// Shared types and defaults for the frog-game collision scanner.
//   scan_state_e   : scanner FSM states
//   TILE_SIZE_DEF  : default side of the square frog/car hitbox, pixels
//   COORD_W_DEF    : default width of every x/y screen coordinate
package collision_scanner_pkg;

    localparam int unsigned TILE_SIZE_DEF = 32;
    localparam int unsigned COORD_W_DEF   = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } scan_state_e;

endpackage : collision_scanner_pkg

// File: rtl/collision_scanner_aabb_overlap.sv
// Strict axis-aligned bounding-box overlap of two TILE_SIZE squares.
//   fx, fy : frog top-left corner
//   cx, cy : car top-left corner
//   hit    : boxes share interior area (touching edges do not count)
// Sums are widened by one bit so a box near the right/bottom screen edge
// cannot wrap around and miss an overlap.
module aabb_overlap
    import collision_scanner_pkg::*;
#(
    parameter int unsigned COORD_W   = COORD_W_DEF,
    parameter int unsigned TILE_SIZE = TILE_SIZE_DEF
) (
    input  logic [COORD_W-1:0] fx,
    input  logic [COORD_W-1:0] fy,
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    output logic               hit
);

    localparam int unsigned SUM_W = COORD_W + 1;

    logic [SUM_W-1:0] tile;
    logic [SUM_W-1:0] fx_e, fy_e, cx_e, cy_e;
    logic             x_ovl, y_ovl;

    assign tile = SUM_W'(TILE_SIZE);
    assign fx_e = SUM_W'(fx);
    assign fy_e = SUM_W'(fy);
    assign cx_e = SUM_W'(cx);
    assign cy_e = SUM_W'(cy);

    // Per-axis interval overlap, then both axes must agree
    always_comb begin
        x_ovl = (fx_e < (cx_e + tile)) && (cx_e < (fx_e + tile));
        y_ovl = (fy_e < (cy_e + tile)) && (cy_e < (fy_e + tile));
        hit   = x_ovl && y_ovl;
    end

endmodule : aabb_overlap

// File: rtl/collision_scanner.sv
// Time-multiplexed frog-vs-cars collision detector.
// On scan_start the frog, all cars and the level are snapshotted, then one
// car per clock is tested against the frog through a single AABB unit.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   scan_start          : frame-tick pulse requesting a scan
//   current_level       : level, sets how many cars are active
//   frog_x, frog_y      : frog top-left
//   car_x_bus/car_y_bus : car i at [i*COORD_W +: COORD_W]
//   busy                : scan or report in progress
//   result_valid        : one-cycle pulse qualifying the results
//   death_collision     : an active car overlaps the frog
//   win_collision       : frog at the top and no death
//   hit_index           : lowest overlapping car, held between results
//   scan_overrun        : scan_start arrived while busy
module collision_scanner
    import collision_scanner_pkg::*;
#(
    parameter int unsigned NUM_CARS       = 10,
    parameter int unsigned COORD_W        = COORD_W_DEF,
    parameter int unsigned TILE_SIZE      = TILE_SIZE_DEF,
    parameter int unsigned LEVEL_W        = 4,
    parameter int unsigned CARS_PER_LEVEL = 2,
    parameter int unsigned WIN_Y          = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          scan_start,
    input  logic [LEVEL_W-1:0]            current_level,
    input  logic [COORD_W-1:0]            frog_x,
    input  logic [COORD_W-1:0]            frog_y,
    input  logic [NUM_CARS*COORD_W-1:0]   car_x_bus,
    input  logic [NUM_CARS*COORD_W-1:0]   car_y_bus,
    output logic                          busy,
    output logic                          result_valid,
    output logic                          death_collision,
    output logic                          win_collision,
    output logic [$clog2(NUM_CARS)-1:0]   hit_index,
    output logic                          scan_overrun
);

    localparam int unsigned IDX_W = $clog2(NUM_CARS);
    localparam int unsigned CNT_W = $clog2(NUM_CARS + 1);
    localparam int unsigned BUS_W = NUM_CARS * COORD_W;

    scan_state_e          state_q, state_d;
    logic [IDX_W-1:0]     counter_q, counter_d;
    logic [CNT_W-1:0]     active_q, active_d;
    logic                 hit_flag_q, hit_flag_d;
    logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;
    logic [COORD_W-1:0]   snap_fx_q, snap_fx_d;
    logic [COORD_W-1:0]   snap_fy_q, snap_fy_d;
    logic [BUS_W-1:0]     snap_cx_q, snap_cx_d;
    logic [BUS_W-1:0]     snap_cy_q, snap_cy_d;

    logic                 busy_q, busy_d;
    logic                 result_valid_q, result_valid_d;
    logic                 death_q, death_d;
    logic                 win_q, win_d;
    logic [IDX_W-1:0]     hit_index_q, hit_index_d;
    logic                 overrun_q, overrun_d;

    logic [31:0]          level_prod_c;
    logic [CNT_W-1:0]     active_cnt_c;
    logic [COORD_W-1:0]   sel_cx_c, sel_cy_c;
    logic                 overlap_c;
    logic                 car_hit_c;

    // Full-precision level*cars product, clamped to the number of slots
    always_comb begin
        level_prod_c = 32'(current_level) * 32'(CARS_PER_LEVEL);
        if (level_prod_c > 32'(NUM_CARS)) begin
            active_cnt_c = CNT_W'(NUM_CARS);
        end else begin
            active_cnt_c = CNT_W'(level_prod_c);
        end
    end

    // Route the car under test from the snapshot into the shared comparator
    assign sel_cx_c = snap_cx_q[counter_q*COORD_W +: COORD_W];
    assign sel_cy_c = snap_cy_q[counter_q*COORD_W +: COORD_W];

    aabb_overlap #(
        .COORD_W   (COORD_W),
        .TILE_SIZE (TILE_SIZE)
    ) u_aabb (
        .fx  (snap_fx_q),
        .fy  (snap_fy_q),
        .cx  (sel_cx_c),
        .cy  (sel_cy_c),
        .hit (overlap_c)
    );

    // Inactive slots are still visited so scan length is level-independent
    assign car_hit_c = overlap_c && (CNT_W'(counter_q) < active_q);

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        counter_d      = counter_q;
        active_d       = active_q;
        hit_flag_d     = hit_flag_q;
        hit_idx_d      = hit_idx_q;
        snap_fx_d      = snap_fx_q;
        snap_fy_d      = snap_fy_q;
        snap_cx_d      = snap_cx_q;
        snap_cy_d      = snap_cy_q;
        result_valid_d = 1'b0;
        death_d        = 1'b0;
        win_d          = 1'b0;
        hit_index_d    = hit_index_q;
        overrun_d      = scan_start && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (scan_start) begin
                    snap_fx_d  = frog_x;
                    snap_fy_d  = frog_y;
                    snap_cx_d  = car_x_bus;
                    snap_cy_d  = car_y_bus;
                    active_d   = active_cnt_c;
                    hit_flag_d = 1'b0;
                    hit_idx_d  = '0;
                    counter_d  = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Only the first hit records its index
                if (car_hit_c && !hit_flag_q) begin
                    hit_flag_d = 1'b1;
                    hit_idx_d  = counter_q;
                end
                if (counter_q == IDX_W'(NUM_CARS - 1)) begin
                    state_d = ST_REPORT;
                end else begin
                    counter_d = counter_q + IDX_W'(1);
                end
            end
            ST_REPORT: begin
                result_valid_d = 1'b1;
                death_d        = hit_flag_q;
                win_d          = (snap_fy_q <= COORD_W'(WIN_Y)) && !hit_flag_q;
                hit_index_d    = hit_idx_q;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            counter_q      <= '0;
            active_q       <= '0;
            hit_flag_q     <= 1'b0;
            hit_idx_q      <= '0;
            snap_fx_q      <= '0;
            snap_fy_q      <= '0;
            snap_cx_q      <= '0;
            snap_cy_q      <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            death_q        <= 1'b0;
            win_q          <= 1'b0;
            hit_index_q    <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            active_q       <= active_d;
            hit_flag_q     <= hit_flag_d;
            hit_idx_q      <= hit_idx_d;
            snap_fx_q      <= snap_fx_d;
            snap_fy_q      <= snap_fy_d;
            snap_cx_q      <= snap_cx_d;
            snap_cy_q      <= snap_cy_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            death_q        <= death_d;
            win_q          <= win_d;
            hit_index_q    <= hit_index_d;
            overrun_q      <= overrun_d;
        end
    end

    assign busy            = busy_q;
    assign result_valid    = result_valid_q;
    assign death_collision = death_q;
    assign win_collision   = win_q;
    assign hit_index       = hit_index_q;
    assign scan_overrun    = overrun_q;

endmodule : collision_scanner

// File: tb/tb_collision_scanner.sv
// Directed plus randomized bench for collision_scanner against a
// rule-level reference model (plain integer box arithmetic).
module tb_collision_scanner;

    localparam int unsigned N    = 10;
    localparam int unsigned CW   = 10;
    localparam int unsigned LW   = 4;
    localparam int unsigned IW   = 4;
    localparam int          TILE = 32;
    localparam int          LAT  = 11;

    logic               clk;
    logic               rst_n;
    logic               scan_start;
    logic [LW-1:0]      current_level;
    logic [CW-1:0]      frog_x, frog_y;
    logic [N*CW-1:0]    car_x_bus, car_y_bus;
    logic               busy, result_valid, death_collision, win_collision;
    logic [IW-1:0]      hit_index;
    logic               scan_overrun;

    collision_scanner dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .scan_start      (scan_start),
        .current_level   (current_level),
        .frog_x          (frog_x),
        .frog_y          (frog_y),
        .car_x_bus       (car_x_bus),
        .car_y_bus       (car_y_bus),
        .busy            (busy),
        .result_valid    (result_valid),
        .death_collision (death_collision),
        .win_collision   (win_collision),
        .hit_index       (hit_index),
        .scan_overrun    (scan_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cxa [N];
    int cya [N];
    int fxv, fyv, lvl;
    logic       exp_death, exp_win;
    logic [31:0] exp_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic bit overlaps(input int fx, input int fy, input int cx, input int cy);
        return (fx < cx + TILE) && (cx < fx + TILE) && (fy < cy + TILE) && (cy < fy + TILE);
    endfunction

    // Reference: first active car overlapping the frog; win only at top with no death
    task automatic model();
        int act;
        act = lvl * 2;
        if (act > int'(N)) act = int'(N);
        exp_death = 1'b0;
        exp_idx   = 0;
        for (int i = 0; i < act; i++) begin
            if (!exp_death && overlaps(fxv, fyv, cxa[i], cya[i])) begin
                exp_death = 1'b1;
                exp_idx   = 32'(i);
            end
        end
        exp_win = (fyv <= 0) && !exp_death;
    endtask

    task automatic drive_inputs();
        current_level = LW'(lvl);
        frog_x = CW'(fxv);
        frog_y = CW'(fyv);
        for (int i = 0; i < int'(N); i++) begin
            car_x_bus[i*CW +: CW] = CW'(cxa[i]);
            car_y_bus[i*CW +: CW] = CW'(cya[i]);
        end
    endtask

    task automatic scramble();
        current_level = LW'($urandom);
        frog_x        = CW'($urandom);
        frog_y        = CW'($urandom);
        for (int i = 0; i < int'(N); i++) begin
            car_x_bus[i*CW +: CW] = CW'($urandom);
            car_y_bus[i*CW +: CW] = CW'($urandom);
        end
    endtask

    task automatic park_cars();
        for (int i = 0; i < int'(N); i++) begin
            cxa[i] = 600;
            cya[i] = 0;
        end
    endtask

    // Wait from cycle start_cyc for the result pulse and compare it with the model
    task automatic finish_scan(input string tag, input int start_cyc);
        int cyc;
        cyc = start_cyc;
        while (result_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(LAT));
        check({tag, " death"}, 32'(death_collision), 32'(exp_death));
        check({tag, " win"}, 32'(win_collision), 32'(exp_win));
        if (exp_death) check({tag, " hit_index"}, 32'(hit_index), exp_idx);
        @(negedge clk);
        check({tag, " valid pulse"}, 32'(result_valid), 32'd0);
    endtask

    task automatic run_scan(input string tag);
        model();
        drive_inputs();
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        scramble();
        check({tag, " busy"}, 32'(busy), 32'd1);
        finish_scan(tag, 0);
    endtask

    initial begin
        int seen_valid;
        rst_n = 1'b0;
        scan_start = 1'b0;
        lvl = 0; fxv = 0; fyv = 0;
        park_cars();
        drive_inputs();
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset valid", 32'(result_valid), 32'd0);
        check("reset death", 32'(death_collision), 32'd0);
        check("reset win", 32'(win_collision), 32'd0);
        check("reset hit_index", 32'(hit_index), 32'd0);
        check("reset overrun", 32'(scan_overrun), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        park_cars(); lvl = 3; fxv = 100; fyv = 200; cxa[4] = 110; cya[4] = 200;
        run_scan("car4 hit");

        park_cars(); lvl = 5; fxv = 64; fyv = 96;
        cxa[2] = 64; cya[2] = 96; cxa[7] = 64; cya[7] = 96;
        run_scan("lowest index");

        park_cars(); lvl = 1; fxv = 300; fyv = 300; cxa[5] = 300; cya[5] = 300;
        run_scan("inactive car5");

        park_cars(); lvl = 0; fxv = 300; fyv = 300; cxa[0] = 300; cya[0] = 300;
        run_scan("level0");

        park_cars(); lvl = 5; fxv = 0; fyv = 0;
        for (int i = 0; i < int'(N); i++) cya[i] = 600;
        run_scan("win");

        park_cars(); lvl = 1; fxv = 0; fyv = 0; cxa[0] = 16; cya[0] = 0;
        run_scan("death beats win");

        park_cars(); lvl = 1; fxv = 990; fyv = 500; cxa[0] = 1000; cya[0] = 500;
        run_scan("no wrap");

        park_cars(); lvl = 1; fxv = 32; fyv = 64; cxa[0] = 64; cya[0] = 64;
        run_scan("touching");
        cxa[0] = 63;
        run_scan("one px overlap");

        // Second scan_start three cycles in must only flag an overrun
        park_cars(); lvl = 3; fxv = 100; fyv = 200; cxa[4] = 110; cya[4] = 200;
        model();
        drive_inputs();
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        repeat (2) @(negedge clk);
        lvl = 0; fxv = 500; fyv = 0; park_cars();
        drive_inputs();
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        check("overrun pulse", 32'(scan_overrun), 32'd1);
        @(negedge clk);
        check("overrun single", 32'(scan_overrun), 32'd0);
        finish_scan("overrun scan", 4);

        // Reset in the middle of a scan aborts without a result
        park_cars(); lvl = 3; fxv = 100; fyv = 200; cxa[4] = 110; cya[4] = 200;
        drive_inputs();
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", 32'(busy), 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (result_valid !== 1'b0) seen_valid++;
            if (i == 2) rst_n = 1'b1;
        end
        check("mid reset no valid", 32'(seen_valid), 32'd0);
        park_cars(); lvl = 5; fxv = 64; fyv = 96; cxa[3] = 80; cya[3] = 110;
        run_scan("after reset");

        // Random scans with cars clustered around the frog
        for (int r = 0; r < 30; r++) begin
            lvl = int'($urandom_range(0, 15));
            fxv = int'($urandom_range(0, 1023));
            fyv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023));
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    cxa[i] = int'($urandom_range(0, 1023));
                    cya[i] = int'($urandom_range(0, 1023));
                end else begin
                    cxa[i] = fxv + int'($urandom_range(0, 80)) - 40;
                    cya[i] = fyv + int'($urandom_range(0, 80)) - 40;
                    if (cxa[i] < 0) cxa[i] = 0;
                    if (cxa[i] > 1023) cxa[i] = 1023;
                    if (cya[i] < 0) cya[i] = 0;
                    if (cya[i] > 1023) cya[i] = 1023;
                end
            end
            run_scan($sformatf("random %0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_collision_scanner
